// File: rtl/uproc_pkg.sv
// Shared definitions for the uProcessor: program-memory geometry, instruction
// encoding helpers and the fetch-control state type.
`ifndef PM_ID_INS_WIDTH
`define PM_ID_INS_WIDTH 15
`endif

package uproc_pkg;

    localparam int PM_INS_W  = `PM_ID_INS_WIDTH;
    localparam int PM_ADDR_W = 8;

    localparam logic [PM_ADDR_W-1:0] RESET_PC    = 8'h00;
    localparam logic [4:0]           OPCODE_HALT = 5'd31;

    typedef logic [PM_INS_W-1:0]  ins_t;
    typedef logic [PM_ADDR_W-1:0] pc_t;

    // IDLE covers the single cycle after reset release before fetching starts;
    // STOP means a HALT is queued, HALT means it has been consumed.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_STOP = 2'd2,
        FS_HALT = 2'd3
    } fetch_state_e;

    function automatic logic is_halt(input logic [4:0] opcode);
        return opcode == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/ins_queue2.sv
// Two-entry instruction prefetch FIFO with synchronous flush; the head reads
// zero when the queue is empty so no stale storage leaks to the decoder.
module ins_queue2
    import uproc_pkg::*;
#(
    parameter int W = PM_INS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & (count_q != 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read,
    // so the data array can map onto plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign count = count_q;
    assign head  = (count_q != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues reads to synchronous program memory, queues
// returned words for the decoder and handles redirects and HALT.
module instruction_fetch
    import uproc_pkg::*;
#(
    parameter int              INS_W    = PM_INS_W,
    parameter int              PC_W     = PM_ADDR_W,
    parameter logic [PC_W-1:0] RESET_PC = uproc_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pm_re,
    output logic [PC_W-1:0]  pm_addr,
    input  logic [INS_W-1:0] pm_rdata,
    output logic [INS_W-1:0] ins,
    output logic             ins_valid,
    input  logic             ins_ready,
    input  logic             jmp_en,
    input  logic [PC_W-1:0]  jmp_addr,
    output logic             halted
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [PC_W-1:0]  pc_q;
    logic             inflight;
    logic [1:0]       q_count;
    logic [INS_W-1:0] q_head;
    logic             run;
    logic             fetch_stop;
    logic             pop;
    logic             push;
    logic             issue;
    logic             push_halt;
    logic             pop_halt;
    logic [2:0]       occupancy;

    assign run        = (state_q != FS_IDLE);
    assign fetch_stop = (state_q == FS_STOP) || (state_q == FS_HALT);
    assign halted     = (state_q == FS_HALT);

    assign ins_valid = (q_count != 2'd0) & ~halted;
    assign ins       = q_head;
    assign pop       = ins_valid & ins_ready;

    // A redirect kills the word returning this cycle; the tag is simply that
    // the return coincides with jmp_en.
    assign push      = inflight & ~jmp_en;
    assign push_halt = push & is_halt(pm_rdata[INS_W-1 -: 5]);
    assign pop_halt  = pop & is_halt(q_head[INS_W-1 -: 5]);

    // Occupancy counts queued plus returning words, credited by this cycle's
    // pop, so back-to-back issue sustains one word per clock without overflow.
    assign occupancy = {1'b0, q_count} + {2'b00, inflight};
    assign issue     = run & ~fetch_stop & ~jmp_en
                     & (occupancy < (3'd2 + {2'b00, pop}));

    assign pm_re   = issue;
    assign pm_addr = pc_q;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_IDLE: state_d = FS_RUN;
            FS_RUN:  if (push_halt) state_d = FS_STOP;
            FS_STOP: if (pop_halt)  state_d = FS_HALT;
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_IDLE;
        endcase
        if (jmp_en) state_d = FS_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FS_IDLE;
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= issue;
            if (jmp_en) begin
                pc_q <= jmp_addr;
            end else if (issue) begin
                pc_q <= pc_q + PC_W'(1);
            end
        end
    end

    ins_queue2 #(
        .W (INS_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (pm_rdata),
        .pop       (pop),
        .flush     (jmp_en),
        .count     (q_count),
        .head      (q_head)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a synchronous program-memory model and
// hand-derived cycle-by-cycle expectations for each scenario.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pm_re;
    logic [7:0]  pm_addr;
    logic [14:0] pm_rdata;
    logic [14:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic        jmp_en;
    logic [7:0]  jmp_addr;
    logic        halted;

    logic [14:0] pm [256];
    int checks = 0;
    int errors = 0;

    localparam logic [14:0] HALT_W = {5'd31, 10'h002};

    instruction_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pm_re     (pm_re),
        .pm_addr   (pm_addr),
        .pm_rdata  (pm_rdata),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .jmp_en    (jmp_en),
        .jmp_addr  (jmp_addr),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Program memory: one-cycle read latency.
    always @(posedge clk) begin
        if (pm_re) pm_rdata <= pm[pm_addr];
    end

    function automatic logic [14:0] word(input int a);
        return 15'h0100 | 15'(a & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic re, input logic [7:0] addr);
        check({tag, ".pm_re"}, {31'd0, pm_re}, {31'd0, re});
        check({tag, ".pm_addr"}, {24'd0, pm_addr}, {24'd0, addr});
    endtask

    task automatic chk_ins(input string tag, input logic v, input logic [14:0] w);
        check({tag, ".ins_valid"}, {31'd0, ins_valid}, {31'd0, v});
        if (v) check({tag, ".ins"}, {17'd0, ins}, {17'd0, w});
    endtask

    // Advance one clock, drive inputs just after the edge, sample 4ns later.
    task automatic cyc(input logic rdy, input logic jen, input logic [7:0] ja);
        @(posedge clk);
        #1;
        ins_ready = rdy;
        jmp_en    = jen;
        jmp_addr  = ja;
        #3;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ins_ready = 1'b0;
        jmp_en    = 1'b0;
        jmp_addr  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) pm[i] = word(i);
        rst_n     = 1'b0;
        ins_ready = 1'b0;
        jmp_en    = 1'b0;
        jmp_addr  = 8'h00;
        #3;
        chk_fetch("reset", 1'b0, 8'h00);
        chk_ins("reset", 1'b0, 15'h0);
        check("reset.ins_zero", {17'd0, ins}, 32'd0);
        check("reset.halted", {31'd0, halted}, 32'd0);

        // 1: streaming fetch, one word per clock.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (k < 4) chk_fetch($sformatf("t1.c%0d", k), 1'b1, 8'(k));
            if (k >= 2) chk_ins($sformatf("t1.c%0d", k), 1'b1, word(k - 2));
        end

        // 2: decoder stall holds A and throttles issue; release with no bubble.
        do_reset();
        cyc(1'b0, 1'b0, 8'h00); chk_fetch("t2.c1", 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00); chk_fetch("t2.c2", 1'b1, 8'h01); chk_ins("t2.c2", 1'b0, 15'h0);
        for (int k = 3; k < 8; k++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk_fetch($sformatf("t2.stall%0d", k), 1'b0, 8'h02);
            chk_ins($sformatf("t2.stall%0d", k), 1'b1, word(0));
        end
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t2.go", 1'b1, 8'h02); chk_ins("t2.go", 1'b1, word(0));
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t2.b", 1'b1, 8'h03); chk_ins("t2.b", 1'b1, word(1));
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t2.c", 1'b1, word(2));
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t2.d", 1'b1, word(3));

        // 3: redirect with a queued word and a fetch in flight.
        do_reset();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h40); chk_fetch("t3.jmp", 1'b0, 8'h02); chk_ins("t3.jmp", 1'b1, word(0));
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t3.c1", 1'b1, 8'h40); chk_ins("t3.c1", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t3.c2", 1'b1, 8'h41); chk_ins("t3.c2", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t3.c3", 1'b1, word(8'h40));
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t3.c4", 1'b1, word(8'h41));

        // 4: HALT at address 2, then resume via redirect.
        pm[2] = HALT_W;
        do_reset();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t4.c3", 1'b1, 8'h02);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t4.c4", 1'b1, 8'h03);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t4.c5", 1'b0, 8'h04); chk_ins("t4.c5", 1'b1, HALT_W);
        check("t4.c5.halted", {31'd0, halted}, 32'd0);
        cyc(1'b1, 1'b0, 8'h00); check("t4.c6.halted", {31'd0, halted}, 32'd1);
        chk_ins("t4.c6", 1'b0, 15'h0); check("t4.c6.head", {17'd0, ins}, {17'd0, word(3)});
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t4.c7", 1'b0, 8'h04);
        check("t4.c7.head", {17'd0, ins}, {17'd0, word(3)});
        cyc(1'b1, 1'b1, 8'h10); chk_fetch("t4.jmp", 1'b0, 8'h04);
        cyc(1'b1, 1'b0, 8'h00); check("t4.r1.halted", {31'd0, halted}, 32'd0);
        chk_fetch("t4.r1", 1'b1, 8'h10); chk_ins("t4.r1", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t4.r2", 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t4.r3", 1'b1, word(8'h10));
        pm[2] = word(2);

        // 5: PC wraps from FF to 00.
        do_reset();
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t5.c1", 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 8'hFE); chk_fetch("t5.jmp", 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t5.fe", 1'b1, 8'hFE); chk_ins("t5.fe", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t5.ff", 1'b1, 8'hFF); chk_ins("t5.ff", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t5.00", 1'b1, 8'h00); chk_ins("t5.00", 1'b1, word(8'hFE));
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t5.01", 1'b1, 8'h01); chk_ins("t5.01", 1'b1, word(8'hFF));
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t5.w0", 1'b1, word(0));

        // 6: asynchronous reset mid-stream, stale read data must be ignored.
        do_reset();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t6.pre", 1'b1, word(0));
        rst_n = 1'b0;
        #1;
        chk_fetch("t6.rst", 1'b0, 8'h00);
        chk_ins("t6.rst", 1'b0, 15'h0);
        check("t6.rst.ins_zero", {17'd0, ins}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h00); chk_fetch("t6.c1", 1'b1, 8'h00); chk_ins("t6.c1", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t6.c2", 1'b0, 15'h0);
        cyc(1'b1, 1'b0, 8'h00); chk_ins("t6.c3", 1'b1, word(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
